mc_sequencer: RTL
=================

Name: mc_sequencer

Overview:
- Multi-cycle control sequencer for the RV32I single-port core.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives the shared memory port (req/ack handshake), IR, PC and register-file write enables.
- Per-instruction ALU/mux decode stays in the existing combinational control unit; this block only schedules when those signals take effect.

Parameters:
- MEM_TIMEOUT, 16, maximum cycles a memory request may wait for mem_ack before a bus error (legal range 1..255).
- CNT_W, 32, width of the retired-instruction and stall counters.

Ports:
- clk  in  1  core clock
- rst  in  1  reset
- run  in  1  level; allows the block to leave IDLE and continue at instruction boundaries
- opcode  in  7  IR[6:0], valid from DECODE onward
- branch_taken  in  1  branch comparison result, sampled in EXEC
- mem_ack  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  request is a write (store)
- mem_addr_sel  out  1  0 = PC (fetch), 1 = ALU result (data)
- ir_we  out  1  load IR from memory read data
- pc_we  out  1  update PC
- pc_src  out  1  0 = PC+4, 1 = branch/jump target
- rf_we  out  1  register-file write strobe
- halted  out  1  sticky halt
- illegal_op  out  1  sticky, halt caused by an unsupported opcode
- bus_err  out  1  sticky, halt caused by memory timeout
- state_o  out  3  current state encoding, for debug
- instret  out  CNT_W  retired-instruction count
- stall_cnt  out  CNT_W  memory wait-cycle count (see Optional Feature)

Behaviour:
- Interface: single clock clk. Reset rst is synchronous and active-high.
- Reset state: IDLE.
  - All outputs are 0, including both counters and all sticky flags.
  - Reset mid-instruction or mid-request aborts immediately; mem_req drops in the cycle after rst is sampled.
- State encoding (state_o): IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- IDLE: run=1 goes to FETCH; otherwise stay in IDLE.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr_sel=0.
  - ir_we = mem_ack. This is combinational (Mealy) and pulses only in the ack cycle.
  - On ack, go to DECODE.
- DECODE: one cycle, classifies opcode.
  - 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1101111 JAL: go to EXEC.
  - 1110011 SYSTEM: go to HALT with halted=1.
  - Any other opcode: go to HALT with halted=1 and illegal_op=1.
- EXEC: one cycle.
  - R, I, JAL: go to WB.
  - LOAD, STORE: go to MEM.
  - BRANCH: pc_we=1, pc_src=branch_taken, instret+=1, then go to the boundary.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=1 for STORE only.
  - On ack, LOAD goes to WB.
  - On ack, STORE drives pc_we=1, pc_src=0, instret+=1, then goes to the boundary.
- WB: rf_we=1, pc_we=1, pc_src=1 for JAL else 0, instret+=1, then go to the boundary.
- Boundary: the next state is FETCH if run=1, else IDLE. run is ignored mid-instruction.
- Timeout:
  - A wait counter clears on entry to FETCH or MEM and increments each cycle mem_req=1 and mem_ack=0.
  - If the counter reaches MEM_TIMEOUT-1 with no ack, the next state is HALT and bus_err=1.
  - An ack in the same cycle as the limit wins: normal progress, no error.
- HALT: all strobes are 0. Only rst exits HALT.
- Handshake:
  - mem_ack is ignored whenever mem_req=0.
  - An ack in the first request cycle is legal (zero-wait memory).
- Latency with zero-wait memory:
  - R, I, JAL: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
- Counters wrap modulo 2^CNT_W with no saturation.
- At most one of {ir_we, rf_we} is high per cycle. pc_we is never high in FETCH, DECODE or HALT.

Optional Feature:
- SEQ_PERF_EN defined:
  - stall_cnt increments on every cycle with mem_req=1 and mem_ack=0.
  - It clears on rst.
- Not defined: stall_cnt is tied to 0 and the counter logic is removed. All other behaviour is identical.

Test Plan:
- rst=1 for 2 cycles, then run=1, zero-wait memory, R-type opcode 0110011 -> state_o sequence 1,2,3,5. rf_we and pc_we (pc_src=0) high in cycle 4. instret=1.
- LOAD 0000011 with 3-cycle data ack, zero-wait fetch -> mem_req held 3 cycles with mem_addr_sel=1 and mem_we=0. rf_we follows in the cycle after ack. stall_cnt=2 with SEQ_PERF_EN, 0 without.
- BRANCH 1100011 with branch_taken=1, then another with branch_taken=0 -> pc_we in EXEC with pc_src=1, then 0. rf_we never asserted. instret=2.
- Opcode 7'b1111111 -> HALT after DECODE with illegal_op=1 and halted=1. No further mem_req despite run=1. rst clears all flags.
- MEM_TIMEOUT=4, fetch mem_ack never asserted -> mem_req high exactly 4 cycles, then HALT with bus_err=1. Repeat with ack on the 4th cycle -> no error, DECODE follows.
- run dropped during a STORE -> STORE completes (mem_we=1, pc_we), then state_o=0 (IDLE). run reasserted -> FETCH next cycle.

Source files
------------

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB scheduler for the RV32I single-port core.
// Define SEQ_PERF_EN to build the memory stall counter on o_stall_cnt (tied to 0 otherwise).
module mc_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_run,
  input  logic [6:0]       i_opcode,
  input  logic             i_branch_taken,
  input  logic             i_mem_ack,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic             o_mem_addr_sel,
  output logic             o_ir_we,
  output logic             o_pc_we,
  output logic             o_pc_src,
  output logic             o_rf_we,
  output logic             o_halted,
  output logic             o_illegal_op,
  output logic             o_bus_err,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_instret,
  output logic [CNT_W-1:0] o_stall_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_ALU, C_JAL, C_LOAD, C_STORE, C_BRANCH
  } cls_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [7:0] WAIT_LIM  = 8'(MEM_TIMEOUT - 1);

  state_t           r_state;
  cls_t             r_cls;
  logic [7:0]       r_wait;
  logic             r_halted;
  logic             r_illegal;
  logic             r_bus_err;
  logic [CNT_W-1:0] r_instret;

  logic   w_req;
  logic   w_ack;
  logic   w_stall;
  logic   w_timeout;
  logic   w_retire;
  state_t w_boundary;

  assign w_req      = (r_state == S_FETCH) || (r_state == S_MEM);
  assign w_ack      = w_req && i_mem_ack;
  assign w_stall    = w_req && !i_mem_ack;
  // An ack on the limit cycle wins, so the timeout only fires on a stalled cycle.
  assign w_timeout  = w_stall && (r_wait == WAIT_LIM);
  assign w_retire   = ((r_state == S_EXEC) && (r_cls == C_BRANCH)) ||
                      ((r_state == S_MEM) && w_ack && (r_cls == C_STORE)) ||
                      (r_state == S_WB);
  assign w_boundary = i_run ? S_FETCH : S_IDLE;

  assign o_mem_req      = w_req;
  assign o_mem_we       = (r_state == S_MEM) && (r_cls == C_STORE);
  assign o_mem_addr_sel = (r_state == S_MEM);
  assign o_ir_we        = (r_state == S_FETCH) && i_mem_ack;
  assign o_pc_we        = w_retire;
  assign o_pc_src       = ((r_state == S_EXEC) && (r_cls == C_BRANCH) && i_branch_taken) ||
                          ((r_state == S_WB) && (r_cls == C_JAL));
  assign o_rf_we        = (r_state == S_WB);
  assign o_halted       = r_halted;
  assign o_illegal_op   = r_illegal;
  assign o_bus_err      = r_bus_err;
  assign o_state        = r_state;
  assign o_instret      = r_instret;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cls     <= C_ALU;
      r_wait    <= '0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
      r_instret <= '0;
    end else begin
      if (w_retire)
        r_instret <= r_instret + CNT_W'(1);
      if (!w_req)
        r_wait <= '0;
      case (r_state)
        S_IDLE:
          if (i_run) r_state <= S_FETCH;
        S_FETCH:
          if (w_ack) begin
            r_wait  <= '0;
            r_state <= S_DECODE;
          end else if (w_timeout) begin
            r_state   <= S_HALT;
            r_halted  <= 1'b1;
            r_bus_err <= 1'b1;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        S_DECODE: begin
          r_state <= S_EXEC;
          case (i_opcode)
            OP_R, OP_I: r_cls <= C_ALU;
            OP_JAL:     r_cls <= C_JAL;
            OP_LOAD:    r_cls <= C_LOAD;
            OP_STORE:   r_cls <= C_STORE;
            OP_BRANCH:  r_cls <= C_BRANCH;
            OP_SYSTEM: begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end
            default: begin
              r_state   <= S_HALT;
              r_halted  <= 1'b1;
              r_illegal <= 1'b1;
            end
          endcase
        end
        S_EXEC:
          case (r_cls)
            C_BRANCH:         r_state <= w_boundary;
            C_LOAD, C_STORE:  r_state <= S_MEM;
            default:          r_state <= S_WB;
          endcase
        S_MEM:
          if (w_ack) begin
            r_wait  <= '0;
            r_state <= (r_cls == C_STORE) ? w_boundary : S_WB;
          end else if (w_timeout) begin
            r_state   <= S_HALT;
            r_halted  <= 1'b1;
            r_bus_err <= 1'b1;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        S_WB:
          r_state <= w_boundary;
        S_HALT:
          r_state <= S_HALT;
        default:
          r_state <= S_HALT;
      endcase
    end
  end

`ifdef SEQ_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_stall_cnt <= '0;
    else if (w_stall)
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_stall_cnt = '0;
`endif

endmodule
